// File: rtl/mem_xfer_pkg.sv
// rtl/mem_xfer_pkg.sv - shared state encodings, mode constants and Len clamp for mem_xfer_ctrl
package mem_xfer_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLR     = 3'd1;
  localparam logic [2:0] S_FILL    = 3'd2;
  localparam logic [2:0] S_REWIND  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_COPY_WR = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [1:0] MODE_FILL      = 2'd0;
  localparam logic [1:0] MODE_COPY      = 2'd1;
  localparam logic [1:0] MODE_FILL_COPY = 2'd2;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_words);
    return (len > max_words) ? max_words : len;
  endfunction

endpackage

// File: rtl/xfer_word_counter.sv
// rtl/xfer_word_counter.sv - per-phase word counter with terminal-count flag against captured Len
module xfer_word_counter
  import mem_xfer_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at len so the count can never run past the programmed length.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q < len_i)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = ((cnt_q + CNT_W'(1)) == len_i);

endmodule

// File: rtl/mem_xfer_ctrl.sv
// rtl/mem_xfer_ctrl.sv - FSM sequencing fill/copy strobes for the A/B memories and address counters
module mem_xfer_ctrl
  import mem_xfer_pkg::*;
#(
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = 4,
  parameter int RD_LAT    = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [CNT_W-1:0] Len,
  input  logic             Abort,
  output logic             WEA,
  output logic             IncA,
  output logic             ClrA,
  output logic             WEB,
  output logic             IncB,
  output logic             ClrB,
  output logic             Busy,
  output logic             Done,
  output logic             Aborted,
  output logic [CNT_W-1:0] WordCnt
);

  localparam logic [2:0] WAIT_INIT = 3'((RD_LAT > 0) ? (RD_LAT - 1) : 0);
  localparam logic [2:0] S_COPY_ENTRY = (RD_LAT == 0) ? S_COPY_WR : S_RD_WAIT;

  logic [2:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [2:0]       wait_q, wait_d;
  logic             active, last_word, cnt_clr, cnt_en;
  logic             wea_q, inca_q, clra_q, web_q, incb_q, clrb_q, busy_q, done_q, aborted_q;
  logic             wea_d, inca_d, clra_d, web_d, incb_d, clrb_d, busy_d, done_d, aborted_d;

  assign active = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    wait_d    = wait_q;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          mode_d  = ((Mode == MODE_FILL) || (Mode == MODE_COPY)) ? Mode : MODE_FILL_COPY;
          len_d   = CNT_W'(clamp_len(32'(Len), 32'(MAX_WORDS)));
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        if (len_q == '0)              state_d = S_DONE;
        else if (mode_q == MODE_COPY) state_d = S_COPY_ENTRY;
        else                          state_d = S_FILL;
      end
      S_FILL: begin
        if (last_word) state_d = (mode_q == MODE_FILL) ? S_DONE : S_REWIND;
      end
      S_REWIND: state_d = S_COPY_ENTRY;
      S_RD_WAIT: begin
        if (wait_q == 3'd0) state_d = S_COPY_WR;
        else                wait_d  = wait_q - 3'd1;
      end
      S_COPY_WR: state_d = last_word ? S_DONE : S_COPY_ENTRY;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (Abort && active) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end
    if ((state_d == S_RD_WAIT) && (state_q != S_RD_WAIT)) wait_d = WAIT_INIT;
  end

  // Outputs are decoded from the next state so every strobe lines up with its state cycle.
  always_comb begin
    wea_d  = (state_d == S_FILL);
    inca_d = (state_d == S_FILL) || (state_d == S_COPY_WR);
    clrb_d = (state_d == S_CLR) && (len_d != '0);
    clra_d = clrb_d || (state_d == S_REWIND);
    web_d  = (state_d == S_COPY_WR);
    incb_d = (state_d == S_COPY_WR);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign cnt_clr = (state_q == S_CLR) || (state_q == S_REWIND) || (Abort && active);
  assign cnt_en  = (state_q == S_FILL) || (state_q == S_COPY_WR);

  xfer_word_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clk_i  (Clk),
    .rst_n_i(Reset_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .len_i  (len_q),
    .cnt_o  (WordCnt),
    .last_o (last_word)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_FILL;
      len_q     <= '0;
      wait_q    <= '0;
      wea_q     <= 1'b0;
      inca_q    <= 1'b0;
      clra_q    <= 1'b0;
      web_q     <= 1'b0;
      incb_q    <= 1'b0;
      clrb_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      wait_q    <= wait_d;
      wea_q     <= wea_d;
      inca_q    <= inca_d;
      clra_q    <= clra_d;
      web_q     <= web_d;
      incb_q    <= incb_d;
      clrb_q    <= clrb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign WEA     = wea_q;
  assign IncA    = inca_q;
  assign ClrA    = clra_q;
  assign WEB     = web_q;
  assign IncB    = incb_q;
  assign ClrB    = clrb_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Aborted = aborted_q;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// tb/tb_mem_xfer_ctrl.sv - scoreboard bench for mem_xfer_ctrl, one instance per RD_LAT of 0, 1 and 2
module tb_mem_xfer_ctrl;

  localparam logic [1:0] M_FILL = 2'd0, M_COPY = 2'd1, M_FC = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v, abort_v;
  logic [1:0] mode_r;
  logic [3:0] len_r;
  logic [2:0] wea, inca, clra, web, incb, clrb, busy, done, aborted;
  logic [3:0] wcnt [3];
  logic [12:0] obs [3];
  logic [12:0] q0[$], q1[$], q2[$];
  int last_cnt [3];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_xfer_ctrl #(.MAX_WORDS(8), .CNT_W(4), .RD_LAT(g)) u_dut (
      .Clk(clk), .Reset_n(rst_n), .Start(start_v[g]), .Mode(mode_r), .Len(len_r),
      .Abort(abort_v[g]), .WEA(wea[g]), .IncA(inca[g]), .ClrA(clra[g]), .WEB(web[g]),
      .IncB(incb[g]), .ClrB(clrb[g]), .Busy(busy[g]), .Done(done[g]), .Aborted(aborted[g]),
      .WordCnt(wcnt[g])
    );
    assign obs[g] = {wea[g], inca[g], clra[g], web[g], incb[g], clrb[g], busy[g], done[g], aborted[g], wcnt[g]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] mk(input bit wea_e, inca_e, clra_e, web_e, incb_e, clrb_e,
                                     input bit busy_e, done_e, ab_e, input int cnt);
    return {wea_e, inca_e, clra_e, web_e, incb_e, clrb_e, busy_e, done_e, ab_e, 4'(cnt)};
  endfunction

  task automatic qpush(input int inst, input logic [12:0] v);
    case (inst)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int inst);
    case (inst)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Instance i runs with RD_LAT=i; builds the cycle-by-cycle output trace from cycle 1 onwards.
  task automatic build_exp(input int inst, input logic [1:0] mode, input int len, input int trunc);
    logic [12:0] seq[$];
    int n, lat;
    logic [1:0] m;
    n = (len > 8) ? 8 : len;
    m = (mode == 2'd3) ? M_FC : mode;
    lat = inst;
    if (n == 0) begin
      seq.push_back(mk(0,0,0,0,0,0,1,0,0,last_cnt[inst]));
      seq.push_back(mk(0,0,0,0,0,0,0,1,0,0));
    end else begin
      seq.push_back(mk(0,0,1,0,0,1,1,0,0,last_cnt[inst]));
      if (m != M_COPY) begin
        for (int i = 0; i < n; i++) seq.push_back(mk(1,1,0,0,0,0,1,0,0,i));
        if (m == M_FILL) seq.push_back(mk(0,0,0,0,0,0,0,1,0,n));
        else             seq.push_back(mk(0,0,1,0,0,0,1,0,0,n));
      end
      if (m != M_FILL) begin
        for (int i = 0; i < n; i++) begin
          for (int w = 0; w < lat; w++) seq.push_back(mk(0,0,0,0,0,0,1,0,0,i));
          seq.push_back(mk(0,1,0,1,1,0,1,0,0,i));
        end
        seq.push_back(mk(0,0,0,0,0,0,0,1,0,n));
      end
    end
    last_cnt[inst] = n;
    if (trunc >= 0) begin
      while (seq.size() > trunc) void'(seq.pop_back());
      seq.push_back(mk(0,0,0,0,0,0,0,0,1,0));
      last_cnt[inst] = 0;
    end
    seq.push_back(mk(0,0,0,0,0,0,0,0,0,last_cnt[inst]));
    seq.push_back(mk(0,0,0,0,0,0,0,0,0,last_cnt[inst]));
    foreach (seq[i]) qpush(inst, seq[i]);
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check_eq("trace_lat0", 32'(obs[0]), 32'(q0.pop_front()));
    if (q1.size() > 0) check_eq("trace_lat1", 32'(obs[1]), 32'(q1.pop_front()));
    if (q2.size() > 0) check_eq("trace_lat2", 32'(obs[2]), 32'(q2.pop_front()));
  end

  task automatic drain(input int inst);
    for (int k = 0; k < 60 && qsize(inst) > 0; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain", 32'(qsize(inst)), 32'd0);
  endtask

  // exp_end: cycle (Start accepted = cycle 0) at which Done or Aborted is expected.
  task automatic run_xfer(input int inst, input logic [1:0] mode, input int len, input int exp_end,
                          input bit exp_abort, input int start_at, input int abort_at);
    int cyc;
    bit seen, got_ab;
    @(negedge clk);
    mode_r = mode;
    len_r  = 4'(len);
    start_v[inst] = 1'b1;
    @(posedge clk);
    #1;
    start_v[inst] = 1'b0;
    build_exp(inst, mode, len, exp_abort ? abort_at : -1);
    cyc = 1;
    seen = 0;
    got_ab = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      start_v[inst] = (cyc == start_at);
      abort_v[inst] = (cyc == abort_at);
      if (done[inst] || aborted[inst]) begin
        seen = 1;
        got_ab = aborted[inst];
      end else begin
        cyc++;
      end
    end
    start_v[inst] = 1'b0;
    abort_v[inst] = 1'b0;
    check_eq("end_cycle", seen ? 32'(cyc) : 32'hffff_ffff, 32'(exp_end));
    check_eq("end_kind_aborted", 32'(got_ab), 32'(exp_abort));
    drain(inst);
  endtask

  initial begin
    rst_n = 1'b0;
    start_v = '0;
    abort_v = '0;
    mode_r = M_FILL;
    len_r = '0;
    for (int i = 0; i < 3; i++) last_cnt[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_eq("reset_state", 32'(obs[i]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_xfer(1, M_FILL, 8, 10, 0, 4, -1);
    run_xfer(2, M_FC, 3, 15, 0, -1, -1);
    run_xfer(0, M_COPY, 12, 10, 0, -1, -1);
    run_xfer(1, M_FILL, 0, 2, 0, -1, -1);
    run_xfer(2, M_FC, 8, 20, 1, -1, 19);
    run_xfer(2, M_FC, 2, 11, 0, -1, -1);
    run_xfer(0, 2'd3, 2, 7, 0, -1, -1);

    // Start and Abort together in IDLE: nothing may happen.
    @(negedge clk);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    qpush(0, mk(0,0,0,0,0,0,0,0,0,last_cnt[0]));
    qpush(0, mk(0,0,0,0,0,0,0,0,0,last_cnt[0]));
    drain(0);

    // Reset dropped mid-FILL must clear outputs without waiting for a clock edge.
    @(negedge clk);
    mode_r = M_FILL;
    len_r = 4'd8;
    start_v[1] = 1'b1;
    @(posedge clk);
    #1;
    start_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("busy_before_reset", 32'(busy[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_outputs", 32'(obs[1]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) last_cnt[i] = 0;
    @(negedge clk);
    check_eq("idle_after_reset", 32'(obs[1]), 32'd0);
    run_xfer(1, M_FC, 2, 9, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
